// File: rtl/ping_pong_match_ctrl_pkg.sv
// Shared definitions for the ping-pong match controller: state encoding,
// player count, default counter width and the round-robin pick helper.
package ping_pong_match_ctrl_pkg;

    localparam int NUM_PLAYERS   = 2;
    localparam int DEFAULT_CNT_W = 4;
    localparam int BOUNCE_W      = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_HOLD = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Round-robin pick: a lone requester always wins, a tie goes to the
    // favoured player (favour = 1 means player 1 is favoured).
    function automatic logic [NUM_PLAYERS-1:0] pick_player(
        input logic [NUM_PLAYERS-1:0] requests,
        input logic                   favour
    );
        logic [NUM_PLAYERS-1:0] pick;
        pick = '0;
        if (requests == 2'b11) begin
            pick = favour ? 2'b10 : 2'b01;
        end else if (requests[0]) begin
            pick = 2'b01;
        end else if (requests[1]) begin
            pick = 2'b10;
        end
        return pick;
    endfunction

endpackage

// File: rtl/ping_pong_match_ctrl_if.sv
// Handshake/status bundle for the ping-pong match controller.
// The pause signal exists only when PP_MATCH_CTRL_PAUSE_EN is defined.
interface ping_pong_match_ctrl_if
    import ping_pong_match_ctrl_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
);

    logic [NUM_PLAYERS-1:0] req;
    logic [BOUNCE_W-1:0]    cfg_bounces;
`ifdef PP_MATCH_CTRL_PAUSE_EN
    logic                   pause;
`endif
    logic                   abort;
    logic [NUM_PLAYERS-1:0] gnt;
    logic                   busy;
    logic                   done;
    logic [CNT_W-1:0]       cnt_out;
    logic                   cnt_dir;
    logic [BOUNCE_W-1:0]    bounce_cnt;

    modport master (
`ifdef PP_MATCH_CTRL_PAUSE_EN
        output pause,
`endif
        output req,
        output cfg_bounces,
        output abort,
        input  gnt,
        input  busy,
        input  done,
        input  cnt_out,
        input  cnt_dir,
        input  bounce_cnt
    );

    modport slave (
`ifdef PP_MATCH_CTRL_PAUSE_EN
        input  pause,
`endif
        input  req,
        input  cfg_bounces,
        input  abort,
        output gnt,
        output busy,
        output done,
        output cnt_out,
        output cnt_dir,
        output bounce_cnt
    );

endinterface

// File: rtl/ping_pong_match_ctrl_step_core.sv
// Combinational ping-pong step: from the current value and direction,
// produce the next value, next direction and whether the step lands on
// an end point (0 or max), which counts as a turnaround.
module pp_step_core #(
    parameter int CNT_W = 4
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             dir,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             dir_nxt,
    output logic             turn
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = 1;

    // End points always reverse, so the counter can never wrap.
    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        if (cnt == '0) begin
            cnt_nxt = cnt + ONE;
            dir_nxt = 1'b1;
        end else if (cnt == CNT_MAX) begin
            cnt_nxt = cnt - ONE;
            dir_nxt = 1'b0;
        end else if (dir) begin
            cnt_nxt = cnt + ONE;
        end else begin
            cnt_nxt = cnt - ONE;
        end
        turn = (cnt_nxt == '0) || (cnt_nxt == CNT_MAX);
    end

endmodule

// File: rtl/ping_pong_match_ctrl.sv
// Ping-pong match controller: round-robin grant of a rally to one of two
// players, a bouncing counter that runs a configured number of turnarounds,
// then a one-cycle done pulse. All outputs are registered.
// Optional feature macro: PP_MATCH_CTRL_PAUSE_EN adds the pause input and
// the HOLD state.
module ping_pong_match_ctrl
    import ping_pong_match_ctrl_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input logic                 clk,
    input logic                 rst,
    ping_pong_match_ctrl_if.slave bus
);

    localparam logic [BOUNCE_W-1:0] ONE_BOUNCE = 1;

    state_t                 state;
    logic [NUM_PLAYERS-1:0] gnt_q;
    logic                   busy_q;
    logic                   done_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   dir_q;
    logic [BOUNCE_W-1:0]    bounce_q;
    logic [BOUNCE_W-1:0]    target_q;
    logic                   favour_q;

    logic [CNT_W-1:0]       cnt_nxt;
    logic                   dir_nxt;
    logic                   turn;
    logic [BOUNCE_W-1:0]    bounce_inc;
    logic [BOUNCE_W-1:0]    target_in;

    pp_step_core #(
        .CNT_W (CNT_W)
    ) u_step (
        .cnt     (cnt_q),
        .dir     (dir_q),
        .cnt_nxt (cnt_nxt),
        .dir_nxt (dir_nxt),
        .turn    (turn)
    );

    assign bounce_inc = bounce_q + ONE_BOUNCE;
    assign target_in  = (bus.cfg_bounces == '0) ? ONE_BOUNCE : bus.cfg_bounces;

    // Rally sequencer: grant, step the counter, finish or abort, and move
    // the round-robin pointer to the other player whenever a rally ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            dir_q    <= 1'b1;
            bounce_q <= '0;
            target_q <= ONE_BOUNCE;
            favour_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        gnt_q    <= pick_player(bus.req, favour_q);
                        state    <= ST_RUN;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        dir_q    <= 1'b1;
                        bounce_q <= '0;
                        target_q <= target_in;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state    <= ST_IDLE;
                        busy_q   <= 1'b0;
                        gnt_q    <= '0;
                        favour_q <= gnt_q[0];
`ifdef PP_MATCH_CTRL_PAUSE_EN
                    end else if (bus.pause) begin
                        state <= ST_HOLD;
`endif
                    end else begin
                        cnt_q <= cnt_nxt;
                        dir_q <= dir_nxt;
                        if (turn) begin
                            bounce_q <= bounce_inc;
                            if (bounce_inc == target_q) begin
                                state  <= ST_DONE;
                                done_q <= 1'b1;
                            end
                        end
                    end
                end
`ifdef PP_MATCH_CTRL_PAUSE_EN
                ST_HOLD: begin
                    if (bus.abort) begin
                        state    <= ST_IDLE;
                        busy_q   <= 1'b0;
                        gnt_q    <= '0;
                        favour_q <= gnt_q[0];
                    end else if (!bus.pause) begin
                        state <= ST_RUN;
                    end
                end
`endif
                ST_DONE: begin
                    state    <= ST_IDLE;
                    busy_q   <= 1'b0;
                    gnt_q    <= '0;
                    favour_q <= gnt_q[0];
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    gnt_q  <= '0;
                end
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cnt_out    = cnt_q;
    assign bus.cnt_dir    = dir_q;
    assign bus.bounce_cnt = bounce_q;

endmodule

// File: tb/tb_ping_pong_match_ctrl.sv
// Self-checking bench for ping_pong_match_ctrl: a table of complete rallies
// plus hand-written sequences for the trace, back-to-back grants, abort,
// pause (PP_MATCH_CTRL_PAUSE_EN) and asynchronous reset.
module tb_ping_pong_match_ctrl;
    import ping_pong_match_ctrl_pkg::*;

    localparam int CNT_W = 4;

    typedef struct {
        logic [1:0] req;
        logic [3:0] cfg;
        int         expGnt;
        int         expBusy;
        int         expCnt;
        int         expBounce;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[6];

    ping_pong_match_ctrl_if #(.CNT_W(CNT_W)) bus();

    ping_pong_match_ctrl #(
        .CNT_W (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic waitCnt(input int value, output int found);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (int'(bus.cnt_out) == value) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic waitIdle(output int found);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (!bus.busy) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [3:0] c,
                                 output int g, output int bc, output int dc,
                                 output int fc, output int fb, output int fg,
                                 output int to);
        bus.req         = r;
        bus.cfg_bounces = c;
        @(negedge clk);
        bus.req = 2'b00;
        g  = int'(bus.gnt);
        bc = 0;
        dc = 0;
        to = 1;
        for (int i = 0; i < 300; i++) begin
            if (!bus.busy) begin
                to = 0;
                break;
            end
            bc++;
            if (bus.done) dc++;
            @(negedge clk);
        end
        fc = int'(bus.cnt_out);
        fb = int'(bus.bounce_cnt);
        fg = int'(bus.gnt);
    endtask

    initial begin
        int g, bc, dc, fc, fb, fg, to, found, n, gap, doneSeen;
        logic prevBusy;
        int grants[3];

        vecs[0] = '{req: 2'b11, cfg: 4'd1, expGnt: 2, expBusy: 16, expCnt: 15, expBounce: 1};
        vecs[1] = '{req: 2'b11, cfg: 4'd2, expGnt: 1, expBusy: 31, expCnt: 0,  expBounce: 2};
        vecs[2] = '{req: 2'b01, cfg: 4'd0, expGnt: 1, expBusy: 16, expCnt: 15, expBounce: 1};
        vecs[3] = '{req: 2'b11, cfg: 4'd3, expGnt: 2, expBusy: 46, expCnt: 15, expBounce: 3};
        vecs[4] = '{req: 2'b10, cfg: 4'd1, expGnt: 2, expBusy: 16, expCnt: 15, expBounce: 1};
        vecs[5] = '{req: 2'b11, cfg: 4'd1, expGnt: 1, expBusy: 16, expCnt: 15, expBounce: 1};

        rst             = 1'b1;
        bus.req         = 2'b00;
        bus.cfg_bounces = 4'd0;
        bus.abort       = 1'b0;
`ifdef PP_MATCH_CTRL_PAUSE_EN
        bus.pause       = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checkOutput("reset_gnt", int'(bus.gnt), 0);
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_done", int'(bus.done), 0);
        checkOutput("reset_cnt", int'(bus.cnt_out), 0);
        checkOutput("reset_dir", int'(bus.cnt_dir), 1);
        checkOutput("reset_bounce", int'(bus.bounce_cnt), 0);
        rst = 1'b0;
        @(negedge clk);

        bus.req         = 2'b01;
        bus.cfg_bounces = 4'd1;
        @(negedge clk);
        bus.req = 2'b00;
        checkOutput("trace_gnt", int'(bus.gnt), 1);
        checkOutput("trace_busy", int'(bus.busy), 1);
        checkOutput("trace_cnt_0", int'(bus.cnt_out), 0);
        checkOutput("trace_dir", int'(bus.cnt_dir), 1);
        checkOutput("trace_bounce_0", int'(bus.bounce_cnt), 0);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            checkOutput($sformatf("trace_cnt_%0d", k), int'(bus.cnt_out), k);
            checkOutput($sformatf("trace_done_%0d", k), int'(bus.done), (k == 15) ? 1 : 0);
        end
        checkOutput("trace_bounce_end", int'(bus.bounce_cnt), 1);
        checkOutput("trace_gnt_in_done", int'(bus.gnt), 1);
        @(negedge clk);
        checkOutput("trace_gnt_after", int'(bus.gnt), 0);
        checkOutput("trace_busy_after", int'(bus.busy), 0);
        checkOutput("trace_done_after", int'(bus.done), 0);
        checkOutput("trace_cnt_retained", int'(bus.cnt_out), 15);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].req, vecs[i].cfg, g, bc, dc, fc, fb, fg, to);
            checkOutput($sformatf("vec%0d_timeout", i), to, 0);
            checkOutput($sformatf("vec%0d_gnt", i), g, vecs[i].expGnt);
            checkOutput($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].expBusy);
            checkOutput($sformatf("vec%0d_done_pulses", i), dc, 1);
            checkOutput($sformatf("vec%0d_cnt", i), fc, vecs[i].expCnt);
            checkOutput($sformatf("vec%0d_bounce", i), fb, vecs[i].expBounce);
            checkOutput($sformatf("vec%0d_gnt_idle", i), fg, 0);
        end

        bus.req         = 2'b11;
        bus.cfg_bounces = 4'd1;
        n        = 0;
        gap      = 0;
        prevBusy = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.busy && !prevBusy) begin
                if (n > 0) checkOutput($sformatf("b2b_gap_%0d", n), gap, 1);
                grants[n] = int'(bus.gnt);
                n++;
                gap = 0;
                if (n == 3) break;
            end
            if (!bus.busy) gap++;
            prevBusy = bus.busy;
        end
        bus.req = 2'b00;
        checkOutput("b2b_grant_count", n, 3);
        if (n == 3) begin
            checkOutput("b2b_gnt_0", grants[0], 2);
            checkOutput("b2b_gnt_1", grants[1], 1);
            checkOutput("b2b_gnt_2", grants[2], 2);
        end
        waitIdle(found);
        checkOutput("b2b_wait_idle", found, 1);

        bus.req         = 2'b01;
        bus.cfg_bounces = 4'd1;
        @(negedge clk);
        bus.req = 2'b00;
        checkOutput("abort_gnt", int'(bus.gnt), 1);
        doneSeen = 0;
        found    = 0;
        for (int i = 0; i < 100; i++) begin
            if (int'(bus.cnt_out) == 7) begin
                found = 1;
                break;
            end
            if (bus.done) doneSeen++;
            @(negedge clk);
        end
        checkOutput("abort_wait_cnt7", found, 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checkOutput("abort_gnt_cleared", int'(bus.gnt), 0);
        checkOutput("abort_busy", int'(bus.busy), 0);
        checkOutput("abort_done", int'(bus.done), 0);
        checkOutput("abort_no_done_before", doneSeen, 0);
        bus.req = 2'b11;
        @(negedge clk);
        bus.req = 2'b00;
        checkOutput("abort_regrant_other", int'(bus.gnt), 2);
        checkOutput("abort_no_late_done", int'(bus.done), 0);
        waitIdle(found);
        checkOutput("abort_wait_idle", found, 1);

`ifdef PP_MATCH_CTRL_PAUSE_EN
        bus.req         = 2'b01;
        bus.cfg_bounces = 4'd1;
        @(negedge clk);
        bus.req = 2'b00;
        checkOutput("pause_gnt", int'(bus.gnt), 1);
        bc    = 0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (int'(bus.cnt_out) == 5) begin
                found = 1;
                break;
            end
            if (bus.busy) bc++;
            @(negedge clk);
        end
        checkOutput("pause_wait_cnt5", found, 1);
        bc++;
        bus.pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.busy) bc++;
            checkOutput($sformatf("pause_hold_%0d", i), int'(bus.cnt_out), 5);
        end
        bus.pause = 1'b0;
        @(negedge clk);
        if (bus.busy) bc++;
        checkOutput("pause_resume_cycle", int'(bus.cnt_out), 5);
        @(negedge clk);
        checkOutput("pause_step_6", int'(bus.cnt_out), 6);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.busy) begin
                found = 1;
                break;
            end
            bc++;
            @(negedge clk);
        end
        checkOutput("pause_wait_idle", found, 1);
        checkOutput("pause_busy_cycles", bc, 20);
`endif

        applyStimulus(2'b01, 4'd1, g, bc, dc, fc, fb, fg, to);
        checkOutput("prereset_timeout", to, 0);
        checkOutput("prereset_gnt", g, 1);

        bus.req         = 2'b10;
        bus.cfg_bounces = 4'd1;
        @(negedge clk);
        bus.req = 2'b00;
        checkOutput("rstmid_gnt", int'(bus.gnt), 2);
        waitCnt(9, found);
        checkOutput("rstmid_wait_cnt9", found, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstmid_gnt_async", int'(bus.gnt), 0);
        checkOutput("rstmid_busy_async", int'(bus.busy), 0);
        checkOutput("rstmid_done_async", int'(bus.done), 0);
        checkOutput("rstmid_cnt_async", int'(bus.cnt_out), 0);
        checkOutput("rstmid_dir_async", int'(bus.cnt_dir), 1);
        checkOutput("rstmid_bounce_async", int'(bus.bounce_cnt), 0);
        @(negedge clk);
        rst     = 1'b0;
        bus.req = 2'b11;
        @(negedge clk);
        bus.req = 2'b00;
        checkOutput("rstmid_pointer_reset", int'(bus.gnt), 1);
        waitIdle(found);
        checkOutput("rstmid_wait_idle", found, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
